// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers for the adder tree stream controller and its FIFO.
package adder_tree_pkg;

    // Width of a tree sum: one extra bit per level of pairwise addition.
    function automatic int sum_width(input int data_w, input int len);
        return data_w + $clog2(len);
    endfunction

    // Width of a counter holding 0..depth inclusive; used as the template for
    // the credit counter type (typedef logic [credit_width(D)-1:0] credit_t).
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// First-word fall-through FIFO with synchronous reset. Pointers wrap explicitly
// so any DEPTH works, not just powers of two.
module sync_fwft_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A read frees the head slot, so a write may land even when full.
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign rd_data = mem[rd_ptr];

    // Storage array: no reset, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adder_tree_stream_ctrl.sv
// Valid/ready shell around an external pipelined adder tree. Tracks which tree
// stages hold real vectors and buffers finished sums; credits reserve a FIFO
// slot for every vector at acceptance so a stalled output never drops a sum.
module adder_tree_stream_ctrl
    import adder_tree_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int LENGTH       = 4,
    parameter int DELAY_STAGES = $clog2(LENGTH),
    parameter int FIFO_DEPTH   = DELAY_STAGES + 2,
    localparam int SUM_WIDTH   = sum_width(DATA_WIDTH, LENGTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_addends_i   [LENGTH],
    output logic [DATA_WIDTH-1:0] tree_addends_o [LENGTH],
    output logic                  tree_advance_o,
    input  logic [SUM_WIDTH-1:0]  tree_sum_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [SUM_WIDTH-1:0]  out_sum_o
);

    localparam int CREDIT_W = credit_width(FIFO_DEPTH);
    typedef logic [CREDIT_W-1:0] credit_t;

    credit_t credits;
    credit_t fifo_count;
    logic    accept, pop, advance, fifo_wr, fifo_empty, fifo_full;
    int      in_flight;

    // Ready depends only on registered credits, never on in_valid/out_ready.
    assign in_ready_o     = (credits != '0) & ~reset;
    assign accept         = in_valid_i & in_ready_o;
    assign out_valid_o    = ~fifo_empty & ~reset;
    assign pop            = out_valid_o & out_ready_i;
    assign tree_addends_o = in_addends_i;
    // Masking with reset keeps the tree's last stage frozen while resetting.
    assign tree_advance_o = ~reset & advance;

    generate
        if (DELAY_STAGES > 0) begin : g_pipe
            logic [DELAY_STAGES-1:0] valid_sr, valid_sr_next;

            // Shift toward bit 0; the new vector (or a bubble) enters at the top.
            always_comb begin
                valid_sr_next = valid_sr >> 1;
                valid_sr_next[DELAY_STAGES-1] = accept;
            end

            // Slot tracking moves only when the tree moves.
            always_ff @(posedge clk) begin
                if (reset)               valid_sr <= '0;
                else if (tree_advance_o) valid_sr <= valid_sr_next;
            end

            // Keep advancing while anything is in flight so every sum reaches
            // bit 0 and is captured exactly once.
            assign advance   = accept | (|valid_sr);
            assign fifo_wr   = valid_sr[0];
            assign in_flight = $countones(valid_sr);
        end else begin : g_comb
            assign advance   = accept;
            assign fifo_wr   = accept;
            assign in_flight = 0;
        end
    endgenerate

    // Credits: one consumed per accepted vector, one returned per popped sum.
    always_ff @(posedge clk) begin
        if (reset)               credits <= credit_t'(FIFO_DEPTH);
        else if (accept && !pop) credits <= credits - credit_t'(1);
        else if (pop && !accept) credits <= credits + credit_t'(1);
    end

    sync_fwft_fifo #(
        .WIDTH (SUM_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (tree_sum_i),
        .rd_en   (pop),
        .rd_data (out_sum_o),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    // Every slot is either free credit, buffered, or in flight.
    a_credit_balance: assert property (@(posedge clk) disable iff (reset)
        int'(credits) + int'(fifo_count) + in_flight == FIFO_DEPTH);

    // Credits guarantee a full FIFO is never written without a pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        fifo_full |-> !(fifo_wr && !pop));

endmodule
